// File: rtl/booth_mul_sequencer.sv
// Operand sequencer and result catcher for the radix-2 Booth multiplier:
// feeds multiplicand then multiplier over a shared bus, then waits for done or timeout.
module booth_mul_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mcand,
  input  logic [WIDTH-1:0]     in_mplier,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_data,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_timeout,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_Q,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [TW-1:0]        timer_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 to_q;
  logic                 in_ready_q;
  logic                 mul_start_q;
  logic [WIDTH-1:0]     mul_data_q;
  logic                 out_valid_q;
  logic                 busy_q;

  // Outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      timer_q     <= '0;
      prod_q      <= '0;
      to_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q     <= in_mcand;
            mplier_q    <= in_mplier;
            mul_start_q <= 1'b1;
            mul_data_q  <= in_mcand;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD_M;
          end
        end
        S_LOAD_M: begin
          mul_data_q <= mplier_q;
          state_q    <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          timer_q <= TW'(TIMEOUT);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q - TW'(1);
          // done wins over expiry when both land in the same cycle
          if (mul_done) begin
            prod_q      <= mul_result;
            to_q        <= 1'b0;
            out_valid_q <= 1'b1;
            mul_data_q  <= mcand_q;
            state_q     <= S_HOLD;
          end else if (timer_q == TW'(1)) begin
            prod_q      <= '0;
            to_q        <= 1'b1;
            out_valid_q <= 1'b1;
            mul_data_q  <= mcand_q;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign mul_start   = mul_start_q;
  assign mul_data    = mul_data_q;
  assign out_valid   = out_valid_q;
  assign out_product = prod_q;
  assign out_timeout = to_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Bench for booth_mul_sequencer: behavioural multiplier with programmable done delay,
// expected products queued at stimulus time and compared when the DUT presents them.
module tb_booth_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_mcand = '0;
  logic [15:0] in_mplier = '0;
  logic        mul_start;
  logic [15:0] mul_data;
  logic        mul_done;
  logic [31:0] mul_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_product;
  logic        out_timeout;
  logic        busy;

  booth_mul_sequencer #(.WIDTH(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier),
    .mul_start(mul_start), .mul_data(mul_data),
    .mul_done(mul_done), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_timeout(out_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {logic [31:0] p; logic t;} exp_t;
  exp_t sb[$];

  // multiplier model: done_delay = cycles after the start cycle; 0 = never
  int          done_delay = 0;
  logic        inj_done = 1'b0;
  logic        model_done;
  logic [31:0] model_res;
  logic [15:0] m_a;
  int          m_phase;
  int          m_cnt;

  function automatic logic [31:0] smul(input logic signed [15:0] x, input logic signed [15:0] y);
    logic signed [31:0] xe, ye;
    xe = x;
    ye = y;
    return xe * ye;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_cnt <= 0; model_done <= 1'b0; model_res <= '0; m_a <= '0;
    end else begin
      model_done <= 1'b0;
      if (mul_start) begin
        m_a <= mul_data; m_phase <= 1; m_cnt <= 1;
      end else if (m_phase == 1) begin
        m_cnt <= 2;
        if (done_delay == 2) begin
          model_done <= 1'b1; model_res <= smul(m_a, mul_data); m_phase <= 0;
        end else begin
          model_res <= smul(m_a, mul_data); m_phase <= 2;
        end
      end else if (m_phase == 2) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == done_delay) begin
          model_done <= 1'b1; m_phase <= 0;
        end
      end
    end
  end

  assign mul_done   = model_done | inj_done;
  assign mul_result = inj_done ? 32'hDEAD_BEEF : model_res;

  // Drive a pair and return #1 after the acceptance edge (cycle N+1 = LOAD_M).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int dly,
                      input logic [31:0] ep, input logic et);
    done_delay = dly;
    in_mcand = a; in_mplier = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{p: ep, t: et});
  endtask

  // lat = cycles since acceptance when out_valid seen (or budget), done_at = last cycle mul_done high
  task automatic wait_out(input int start, input int budget, output int lat, output int done_at);
    lat = start; done_at = -1;
    while (!out_valid && lat < budget) begin
      if (mul_done) done_at = lat;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({in_ready, out_valid, busy, mul_start, out_timeout} !== 5'b10000) $display("FAIL reset_flags got %b want 10000", {in_ready, out_valid, busy, mul_start, out_timeout});
    else n_pass++;
    n_total++;
    if (out_product !== 32'h0 || mul_data !== 16'h0) $display("FAIL reset_data got prod=%h data=%h want 0/0", out_product, mul_data);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_t e; int lat, dat;
    send(16'hFFFD, 16'h0007, 18, 32'hFFFF_FFEB, 1'b0);
    n_total++;
    if (mul_start !== 1'b1 || mul_data !== 16'hFFFD) $display("FAIL basic_load_m got start=%b data=%h want 1/fffd", mul_start, mul_data);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (mul_start !== 1'b0 || mul_data !== 16'h0007) $display("FAIL basic_load_q got start=%b data=%h want 0/0007", mul_start, mul_data);
    else n_pass++;
    wait_out(2, 200, lat, dat);
    n_total++;
    if (out_valid !== 1'b1 || lat !== 20 || dat !== 19) $display("FAIL basic_latency got valid=%b lat=%0d done_at=%0d want 1/20/19", out_valid, lat, dat);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (out_product !== e.p || out_timeout !== e.t) $display("FAIL basic_product got %h/%b want %h/%b", out_product, out_timeout, e.p, e.t);
    else n_pass++;
    take();
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL basic_release got rdy=%b busy=%b vld=%b want 1/0/0", in_ready, busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_corners();
    logic [15:0] ta[4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    logic [15:0] tb[4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
    logic [31:0] tp[4] = '{32'h4000_0000, 32'hC000_8000, 32'h0000_0000, 32'h0000_0001};
    int          td[4] = '{10, 25, 2, 7};
    exp_t e; int lat, dat;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], td[i], tp[i], 1'b0);
      wait_out(1, 200, lat, dat);
      e = sb.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || lat !== td[i] + 2 || out_product !== e.p || out_timeout !== e.t)
        $display("FAIL corner_%0d got vld=%b lat=%0d prod=%h to=%b want 1/%0d/%h/%b", i, out_valid, lat, out_product, out_timeout, td[i] + 2, e.p, e.t);
      else n_pass++;
      take();
    end
  endtask

  task automatic test_timeout();
    exp_t e; int lat, dat;
    send(16'h0011, 16'h0022, 0, 32'h0, 1'b1);
    wait_out(1, 200, lat, dat);
    e = sb.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || lat !== 67) $display("FAIL timeout_latency got vld=%b lat=%0d want 1/67", out_valid, lat);
    else n_pass++;
    n_total++;
    if (out_product !== e.p || out_timeout !== e.t) $display("FAIL timeout_result got %h/%b want %h/%b", out_product, out_timeout, e.p, e.t);
    else n_pass++;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1 || out_product !== 32'h0 || out_timeout !== 1'b1) $display("FAIL timeout_late_done got vld=%b prod=%h to=%b want 1/0/1", out_valid, out_product, out_timeout);
    else n_pass++;
    take();
  endtask

  task automatic test_priority();
    exp_t e; int lat, dat;
    send(16'h0005, 16'hFFFE, 65, 32'hFFFF_FFF6, 1'b0);
    wait_out(1, 200, lat, dat);
    e = sb.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || lat !== 67 || out_product !== e.p || out_timeout !== e.t)
      $display("FAIL priority got vld=%b lat=%0d prod=%h to=%b want 1/67/%h/%b", out_valid, lat, out_product, out_timeout, e.p, e.t);
    else n_pass++;
    take();
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat, dat; int bad;
    send(16'd100, 16'd200, 5, 32'h0000_4E20, 1'b0);
    wait_out(1, 200, lat, dat);
    e = sb.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || out_product !== e.p || out_timeout !== e.t) $display("FAIL b2b_first got vld=%b prod=%h to=%b want 1/%h/%b", out_valid, out_product, out_timeout, e.p, e.t);
    else n_pass++;
    in_mcand = 16'd3; in_mplier = 16'd4; in_valid = 1'b1; done_delay = 6;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || mul_start !== 1'b0 || out_valid !== 1'b1 || out_product !== e.p) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL b2b_backpressure got %0d bad cycles want 0", bad);
    else n_pass++;
    sb.push_back('{p: 32'h0000_000C, t: 1'b0});
    take();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_ready_next got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (mul_start !== 1'b1 || mul_data !== 16'd3 || in_ready !== 1'b0) $display("FAIL b2b_second_start got start=%b data=%h rdy=%b want 1/0003/0", mul_start, mul_data, in_ready);
    else n_pass++;
    wait_out(1, 200, lat, dat);
    e = sb.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || lat !== 8 || out_product !== e.p || out_timeout !== e.t)
      $display("FAIL b2b_second got vld=%b lat=%0d prod=%h to=%b want 1/8/%h/%b", out_valid, lat, out_product, out_timeout, e.p, e.t);
    else n_pass++;
    take();
  endtask

  task automatic test_reset_mid_wait();
    exp_t e; int lat, dat; int seen;
    send(16'h0042, 16'h0003, 0, 32'h0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    n_total++;
    if ({in_ready, out_valid, busy, mul_start} !== 4'b1000) $display("FAIL rst_mid_wait got rdy/vld/busy/start=%b want 1000", {in_ready, out_valid, busy, mul_start});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL rst_no_output got %0d active cycles want 0", seen);
    else n_pass++;
    send(16'd9, 16'd9, 3, 32'h0000_0051, 1'b0);
    wait_out(1, 200, lat, dat);
    e = sb.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || lat !== 5 || out_product !== e.p || out_timeout !== e.t)
      $display("FAIL rst_recover got vld=%b lat=%0d prod=%h to=%b want 1/5/%h/%b", out_valid, lat, out_product, out_timeout, e.p, e.t);
    else n_pass++;
    take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_timeout();
    test_priority();
    test_back_to_back();
    test_reset_mid_wait();
    n_total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/booth_mul_sequencer.md
# booth_mul_sequencer

Upstream operand sequencer and result catcher for the 16-bit radix-2 Booth multiplier datapath. It accepts an operand pair over a valid/ready handshake and drives the multiplier's shared data bus and start pulse: multiplicand first, multiplier second. It then waits for the multiplier controller's done flag, or a timeout, and presents the signed 32-bit product over a second valid/ready handshake. The block holds one transaction at a time; a new operand pair is accepted only after the previous product has been taken.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH
- TIMEOUT, 64, cycles to wait in WAIT for mul_done before flagging an error; must be ≥ WIDTH+4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in IDLE
- in_mcand  in  WIDTH  signed multiplicand
- in_mplier  in  WIDTH  signed multiplier
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_data  out  WIDTH  shared operand bus to the multiplier
- mul_done  in  1  multiplier controller done flag
- mul_result  in  2*WIDTH  multiplier {A,Q} product
- out_valid  out  1  product valid, high only in HOLD
- out_ready  in  1  consumer accepts product
- out_product  out  2*WIDTH  signed product; 0 on timeout
- out_timeout  out  1  qualifies out_product; 1 = multiplier never reported done
- busy  out  1  high in every state except IDLE

## Operation
- Registers: mcand_r and mplier_r (WIDTH each), timer (ceil(log2(TIMEOUT+1)) bits), prod_r (2*WIDTH), to_r (1).
- FSM states are IDLE, LOAD_M, LOAD_Q, WAIT and HOLD. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_mcand and in_mplier, then go to LOAD_M.
- LOAD_M: mul_start=1 and mul_data=mcand_r. Go to LOAD_Q unconditionally.
- LOAD_Q: mul_start=0 and mul_data=mplier_r. Load timer=TIMEOUT, then go to WAIT.
- WAIT: mul_data=mplier_r. Timer decrements by 1 each cycle.
  - If mul_done=1: prod_r←mul_result, to_r←0, go to HOLD.
  - Else if timer==1: prod_r←0, to_r←1, go to HOLD.
  - mul_done has priority over timer expiry in the same cycle.
- HOLD: out_valid=1, with out_product=prod_r and out_timeout=to_r stable. On out_ready, go to IDLE.
- mul_data outside LOAD_M, LOAD_Q and WAIT is mcand_r.
- mul_done is ignored in every state except WAIT.
- mul_result is captured unmodified. No sign extension or rounding is applied; the Booth datapath already produces the two's-complement product.
- in_valid while not in IDLE is ignored. The upstream source must hold its data until in_ready.
- out_ready outside HOLD has no effect.

## Timing
- Reset (async assert, synchronous to clk on deassert): state=IDLE; mcand_r, mplier_r, prod_r, to_r and timer = 0; all outputs 0 except in_ready=1.
- Reset mid-transaction aborts immediately with no output. mul_start drops in the same cycle rst rises.
- Handshake accepted at edge N: LOAD_M occupies cycle N+1 (mul_start high for exactly this cycle); LOAD_Q occupies cycle N+2; WAIT starts at cycle N+3.
- mul_done sampled high at edge D: out_valid=1 from cycle D+1.
- Minimum latency from acceptance to out_valid is 4 cycles, which occurs when mul_done is high in the first WAIT cycle.
- Timeout path: out_valid rises exactly TIMEOUT+3 cycles after acceptance.
- out_ready high at edge H while in HOLD: IDLE at H+1, so in_ready=1 at H+1. The next acceptance is no earlier than edge H+1.
- Back-pressure: HOLD persists indefinitely and out_product is held stable while out_valid=1 and out_ready=0.

## Test plan
- Basic product: in_mcand=-3 (16'hFFFD), in_mplier=7, and the multiplier model raises mul_done 18 cycles after start. Required: mul_data=FFFD in LOAD_M and 0007 in LOAD_Q; out_product=32'hFFFFFFEB; out_timeout=0; out_valid exactly 1 cycle after mul_done.
- Corner operands: pairs 16'h8000×16'h8000, 16'h7FFF×16'h8000 and 0×16'h1234. Required products: 32'h40000000, 32'hC0008000 and 0.
- Timeout: mul_done held at 0 with TIMEOUT=64. Required: out_valid at cycle 67 after acceptance, out_product=0, out_timeout=1. A mul_done pulse arriving after HOLD is entered is ignored.
- Priority: mul_done=1 in the same cycle that timer==1. Required: out_timeout=0 and out_product=mul_result.
- Back-pressure and throughput: hold out_ready=0 for 10 cycles in HOLD with in_valid=1 throughout. Required: in_ready=0, stable product, and no second mul_start. After out_ready=1, in_ready rises the next cycle and a second pair completes correctly.
- Reset mid-WAIT: assert rst during cycle 5 of WAIT. Required: immediate IDLE, out_valid=0, in_ready=1, and no product emitted. A new transaction after reset completes normally.
